// File: rtl/fft_stream_frame_pkg.sv
// Shared definitions for the fft_stream_frame slice: FSM state encoding,
// default geometry constants and the bit-reverse index helper.
package fft_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_N       = 16;
  localparam int DEF_Q       = 8;
  localparam int DEF_POINTS  = 16;
  localparam int DEF_TIMEOUT = 256;
  localparam int MAX_LOG2    = 10;

  // Reverse the low 'bits' bits of v; upper bits of the result are zero.
  function automatic logic [MAX_LOG2-1:0] bit_rev(input logic [MAX_LOG2-1:0] v,
                                                  input int unsigned bits);
    logic [MAX_LOG2-1:0] r;
    logic [3:0]          src;
    r = '0;
    for (int i = 0; i < MAX_LOG2; i++) begin
      if (i < int'(bits)) begin
        src  = 4'(int'(bits) - 1 - i);
        r[i] = v[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stream_frame_if.sv
// Handshake and bus bundle between fft_stream_frame and its surroundings:
// serial sample input, parallel core buses, serial result output, status.
// The slave modport is the adapter; master is the source/core/sink side.
interface fft_stream_frame_if
  import fft_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int POINTS = DEF_POINTS
);
  localparam int IW = $clog2(POINTS);

  logic                   i_in_valid;
  logic                   o_in_ready;
  logic signed [N-1:0]    i_in_re;
  logic signed [N-1:0]    i_in_im;
  logic                   i_in_last;

  logic [POINTS*N-1:0]    o_core_re;
  logic [POINTS*N-1:0]    o_core_im;
  logic                   o_core_start;
  logic [POINTS*N-1:0]    i_core_re;
  logic [POINTS*N-1:0]    i_core_im;
  logic                   i_core_done;

  logic                   o_out_valid;
  logic                   i_out_ready;
  logic signed [N-1:0]    o_out_re;
  logic signed [N-1:0]    o_out_im;
  logic [IW-1:0]          o_out_idx;
  logic                   o_out_last;

  logic                   o_frame_err;
  logic                   o_timeout;

  modport slave (
    input  i_in_valid, i_in_re, i_in_im, i_in_last,
    input  i_core_re, i_core_im, i_core_done,
    input  i_out_ready,
    output o_in_ready, o_core_re, o_core_im, o_core_start,
    output o_out_valid, o_out_re, o_out_im, o_out_idx, o_out_last,
    output o_frame_err, o_timeout
  );

  modport master (
    output i_in_valid, i_in_re, i_in_im, i_in_last,
    output i_core_re, i_core_im, i_core_done,
    output i_out_ready,
    input  o_in_ready, o_core_re, o_core_im, o_core_start,
    input  o_out_valid, o_out_re, o_out_im, o_out_idx, o_out_last,
    input  o_frame_err, o_timeout
  );

endinterface

// File: rtl/fft_stream_frame_buf.sv
// fft_frame_buf: POINTS complex samples held as flat re/im registers.
// Supports a single indexed write or a whole-frame parallel load (load wins),
// and exposes the full contents on flat read buses. Cleared on reset.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int POINTS = DEF_POINTS
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(POINTS)-1:0] wr_idx,
  input  logic signed [N-1:0]       wr_re,
  input  logic signed [N-1:0]       wr_im,
  input  logic                      ld_en,
  input  logic [POINTS*N-1:0]       ld_re,
  input  logic [POINTS*N-1:0]       ld_im,
  output logic [POINTS*N-1:0]       rd_re,
  output logic [POINTS*N-1:0]       rd_im
);

  logic [POINTS*N-1:0] mem_re;
  logic [POINTS*N-1:0] mem_im;

  // Sample storage: parallel load takes priority over the indexed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_re <= '0;
      mem_im <= '0;
    end else if (ld_en) begin
      mem_re <= ld_re;
      mem_im <= ld_im;
    end else if (wr_en) begin
      mem_re[int'(wr_idx)*N +: N] <= wr_re;
      mem_im[int'(wr_idx)*N +: N] <= wr_im;
    end
  end

  assign rd_re = mem_re;
  assign rd_im = mem_im;

endmodule

// File: rtl/fft_stream_frame.sv
// fft_stream_frame: serial <-> parallel adapter around a POINTS-point FFT core.
// FILL collects one frame, RUN waits for the core (with a timeout watchdog),
// DRAIN streams the captured result out with bin index and last marker.
// Build option FFT_BITREV_EN: the core result is taken to be in bit-reversed
// order and is reordered so the output stream is in natural bin order.
module fft_stream_frame
  import fft_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int Q       = DEF_Q,
  parameter int POINTS  = DEF_POINTS,
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input logic i_clk,
  input logic i_rst,
  fft_stream_frame_if.slave bus
);

  localparam int IW = $clog2(POINTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(POINTS - 1);
  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);

  if (POINTS < 4 || POINTS > 1024 || (POINTS & (POINTS - 1)) != 0 ||
      Q < 0 || Q >= N || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_cfg_check
    $error("fft_stream_frame: unsupported parameter set");
  end

  state_t              state;
  logic [IW-1:0]       wr_cnt;
  logic [IW-1:0]       rd_cnt;
  logic [15:0]         tcnt;
  logic                core_start;
  logic                frame_err;
  logic                timeout_pulse;
  logic                out_valid;
  logic                out_last;
  logic signed [N-1:0] out_re;
  logic signed [N-1:0] out_im;

  logic                in_hs;
  logic                wr_final;
  logic                in_wr_en;
  logic                core_accept;
  logic [IW-1:0]       rd_nxt;
  logic [POINTS*N-1:0] ob_re;
  logic [POINTS*N-1:0] ob_im;

  // Buffer position holding output bin k.
  function automatic logic [IW-1:0] src_pos(input logic [IW-1:0] k);
`ifdef FFT_BITREV_EN
    logic [MAX_LOG2-1:0] r;
    r = bit_rev(MAX_LOG2'(k), IW);
    return r[IW-1:0];
`else
    return k;
`endif
  endfunction

  // One sample out of a flat POINTS*N bus.
  function automatic logic signed [N-1:0] pick(input logic [POINTS*N-1:0] flat,
                                               input logic [IW-1:0] pos);
    return flat[int'(pos)*N +: N];
  endfunction

  assign in_hs       = bus.i_in_valid && (state == FILL);
  assign wr_final    = (wr_cnt == LAST_IDX);
  // A premature last discards the frame, so that sample is not stored.
  assign in_wr_en    = in_hs && (wr_final || !bus.i_in_last);
  // The start cycle itself never accepts done.
  assign core_accept = (state == RUN) && bus.i_core_done && !core_start;
  assign rd_nxt      = rd_cnt + 1'b1;

  fft_frame_buf #(.N(N), .POINTS(POINTS)) u_in_buf (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (in_wr_en),
    .wr_idx (wr_cnt),
    .wr_re  (bus.i_in_re),
    .wr_im  (bus.i_in_im),
    .ld_en  (1'b0),
    .ld_re  ('0),
    .ld_im  ('0),
    .rd_re  (bus.o_core_re),
    .rd_im  (bus.o_core_im)
  );

  fft_frame_buf #(.N(N), .POINTS(POINTS)) u_out_buf (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (1'b0),
    .wr_idx ('0),
    .wr_re  ('0),
    .wr_im  ('0),
    .ld_en  (core_accept),
    .ld_re  (bus.i_core_re),
    .ld_im  (bus.i_core_im),
    .rd_re  (ob_re),
    .rd_im  (ob_im)
  );

  // Frame control FSM with registered status and output-stream registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= FILL;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      tcnt          <= '0;
      core_start    <= 1'b0;
      frame_err     <= 1'b0;
      timeout_pulse <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_re        <= '0;
      out_im        <= '0;
    end else begin
      core_start    <= 1'b0;
      frame_err     <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        FILL: begin
          if (in_hs) begin
            if (wr_final) begin
              wr_cnt     <= '0;
              tcnt       <= '0;
              core_start <= 1'b1;
              frame_err  <= !bus.i_in_last;
              state      <= RUN;
            end else if (bus.i_in_last) begin
              wr_cnt    <= '0;
              frame_err <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          tcnt <= tcnt + 1'b1;
          if (core_accept) begin
            rd_cnt    <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_re    <= pick(bus.i_core_re, src_pos('0));
            out_im    <= pick(bus.i_core_im, src_pos('0));
            state     <= DRAIN;
          end else if (tcnt == TO_LAST) begin
            timeout_pulse <= 1'b1;
            state         <= FILL;
          end
        end
        DRAIN: begin
          if (bus.i_out_ready) begin
            if (rd_cnt == LAST_IDX) begin
              rd_cnt    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= FILL;
            end else begin
              rd_cnt   <= rd_nxt;
              out_last <= (rd_nxt == LAST_IDX);
              out_re   <= pick(ob_re, src_pos(rd_nxt));
              out_im   <= pick(ob_im, src_pos(rd_nxt));
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.o_in_ready   = (state == FILL);
  assign bus.o_core_start = core_start;
  assign bus.o_out_valid  = out_valid;
  assign bus.o_out_re     = out_re;
  assign bus.o_out_im     = out_im;
  assign bus.o_out_idx    = rd_cnt;
  assign bus.o_out_last   = out_last;
  assign bus.o_frame_err  = frame_err;
  assign bus.o_timeout    = timeout_pulse;

endmodule

// File: tb/tb_fft_stream_frame.sv
// Bench for fft_stream_frame: table of frame scenarios plus hand-written
// sequences (done in the start cycle, timeout, reset during drain).
// Expected outputs come from a simple frame model kept in this file.
module tb_fft_stream_frame;

  localparam int N    = 16;
  localparam int P    = 16;
  localparam int LOGP = 4;
  localparam int TO   = 20;
  localparam int W    = P * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_stream_frame_if #(.N(N), .POINTS(P)) bus ();

  fft_stream_frame #(.N(N), .Q(8), .POINTS(P), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [N-1:0] in_re  [P];
  logic signed [N-1:0] in_im  [P];
  logic signed [N-1:0] res_re [P];
  logic signed [N-1:0] res_im [P];

  typedef struct {
    int len;        // samples sent
    int last_at;    // index carrying i_in_last, -1 for none
    int ready_mode; // 0 always ready, 1 toggling 1010, 2 random
    int res_mode;   // 0 echo input, 1 value p at position p, 2 random
    int delay;      // idle RUN cycles before done
    bit ramp;       // input x[k] = k + j0
    bit exp_err;
    bit exp_start;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output bin k comes from this position of the core result.
  function automatic int nat_pos(input int k);
    int r;
    int v;
    r = k;
`ifdef FFT_BITREV_EN
    r = 0;
    v = k;
    for (int b = 0; b < LOGP; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
`else
    v = 0;
`endif
    return r + v * 0;
  endfunction

  function automatic logic [W-1:0] flat_in_re();
    logic [W-1:0] f;
    for (int k = 0; k < P; k++) f[k*N +: N] = in_re[k];
    return f;
  endfunction

  function automatic logic [W-1:0] flat_in_im();
    logic [W-1:0] f;
    for (int k = 0; k < P; k++) f[k*N +: N] = in_im[k];
    return f;
  endfunction

  function automatic logic [W-1:0] flat_res_re();
    logic [W-1:0] f;
    for (int k = 0; k < P; k++) f[k*N +: N] = res_re[k];
    return f;
  endfunction

  function automatic logic [W-1:0] flat_res_im();
    logic [W-1:0] f;
    for (int k = 0; k < P; k++) f[k*N +: N] = res_im[k];
    return f;
  endfunction

  function automatic logic [W-1:0] junk_bus();
    logic [W-1:0] f;
    for (int k = 0; k < W / 32; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic fill_data(input bit ramp, input int res_mode);
    for (int k = 0; k < P; k++) begin
      in_re[k] = ramp ? N'(k) : N'($urandom);
      in_im[k] = ramp ? '0 : N'($urandom);
    end
    for (int k = 0; k < P; k++) begin
      case (res_mode)
        0: begin res_re[k] = in_re[k]; res_im[k] = in_im[k]; end
        1: begin res_re[k] = N'(k);    res_im[k] = N'(100 + k); end
        default: begin res_re[k] = N'($urandom); res_im[k] = N'($urandom); end
      endcase
    end
  endtask

  // Feed len samples (with random idle gaps); ends on the negedge after the final handshake.
  task automatic send_frame(input int len, input int last_at);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        bus.i_in_valid  = 1'b0;
        bus.i_core_done = 1'($urandom_range(1));
        bus.i_core_re   = junk_bus();
      end
      @(negedge clk);
      if (i == 0) check("in_ready_fill", W'(bus.o_in_ready), W'(1));
      bus.i_in_valid  = 1'b1;
      bus.i_in_re     = in_re[i];
      bus.i_in_im     = in_im[i];
      bus.i_in_last   = (i == last_at);
      bus.i_core_done = 1'($urandom_range(1));
      bus.i_core_re   = junk_bus();
    end
    @(negedge clk);
    bus.i_in_valid  = 1'b0;
    bus.i_in_last   = 1'b0;
    bus.i_core_done = 1'b0;
  endtask

  // Hold the core idle for 'delay' cycles (junk input traffic), then return
  // the result; ends on the negedge where done is driven.
  task automatic run_core(input int delay);
    check("core_re_bus", bus.o_core_re, flat_in_re());
    check("core_im_bus", bus.o_core_im, flat_in_im());
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (bus.o_out_valid !== 1'b0) check("run_no_out_valid", W'(bus.o_out_valid), W'(0));
      if (bus.o_core_start !== 1'b0) check("start_single", W'(bus.o_core_start), W'(0));
      bus.i_in_valid = 1'($urandom_range(1));
      bus.i_in_re    = N'($urandom);
      bus.i_in_last  = 1'($urandom_range(1));
    end
    @(negedge clk);
    bus.i_in_valid  = 1'b0;
    bus.i_in_last   = 1'b0;
    bus.i_core_done = 1'b1;
    bus.i_core_re   = flat_res_re();
    bus.i_core_im   = flat_res_im();
  endtask

  // Collect the output stream and compare every bin; optionally reset at bin stop_at.
  task automatic drain(input int mode, input int stop_at);
    int k;
    bit rdy;
    k = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      bus.i_core_done = 1'($urandom_range(1));
      bus.i_core_re   = junk_bus();
      bus.i_core_im   = junk_bus();
      if (k == P) begin
        check("drain_end_valid", W'(bus.o_out_valid), W'(0));
        check("drain_end_in_ready", W'(bus.o_in_ready), W'(1));
        bus.i_out_ready = 1'b0;
        bus.i_core_done = 1'b0;
        return;
      end
      check("out_valid", W'(bus.o_out_valid), W'(1));
      check("out_idx", W'(bus.o_out_idx), W'(k));
      check("out_re", W'(bus.o_out_re), W'(res_re[nat_pos(k)]));
      check("out_im", W'(bus.o_out_im), W'(res_im[nat_pos(k)]));
      check("out_last", W'(bus.o_out_last), W'(k == P - 1));
      if (k == stop_at) begin
        rst = 1'b1;
        bus.i_out_ready = 1'b0;
        bus.i_core_done = 1'b0;
        @(negedge clk);
        check("rst_out_valid", W'(bus.o_out_valid), W'(0));
        check("rst_out_idx", W'(bus.o_out_idx), W'(0));
        check("rst_out_re", W'(bus.o_out_re), W'(0));
        check("rst_core_re", bus.o_core_re, W'(0));
        check("rst_pulses", W'({bus.o_frame_err, bus.o_timeout, bus.o_core_start}), W'(0));
        check("rst_in_ready", W'(bus.o_in_ready), W'(1));
        rst = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      bus.i_out_ready = rdy;
      if (rdy) k++;
    end
    check("drain_budget", W'(0), W'(1));
  endtask

  task automatic do_frame(input vec_t v, input int stop_at);
    fill_data(v.ramp, v.res_mode);
    send_frame(v.len, v.last_at);
    check("frame_err", W'(bus.o_frame_err), W'(v.exp_err));
    check("core_start", W'(bus.o_core_start), W'(v.exp_start));
    if (v.exp_start) begin
      run_core(v.delay);
      drain(v.ready_mode, stop_at);
    end else begin
      @(negedge clk);
      check("no_start_in_ready", W'(bus.o_in_ready), W'(1));
      check("err_single", W'(bus.o_frame_err), W'(0));
    end
  endtask

  function automatic vec_t mk(input int len, input int last_at, input int rm, input int sm,
                              input int dly, input bit ramp, input bit err, input bit st);
    vec_t v;
    v.len = len; v.last_at = last_at; v.ready_mode = rm; v.res_mode = sm;
    v.delay = dly; v.ramp = ramp; v.exp_err = err; v.exp_start = st;
    return v;
  endfunction

  vec_t tbl [8];
  vec_t rv;
  int   cnt;
  bit   seen;

  initial begin
    tbl[0] = mk(16, 15, 0, 0,  4, 1'b1, 1'b0, 1'b1);
    tbl[1] = mk(16, 15, 1, 2,  0, 1'b0, 1'b0, 1'b1);
    tbl[2] = mk( 8,  7, 0, 2,  0, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(16, 15, 2, 2,  2, 1'b0, 1'b0, 1'b1);
    tbl[4] = mk(16, -1, 2, 2,  1, 1'b0, 1'b1, 1'b1);
    tbl[5] = mk( 1,  0, 0, 2,  0, 1'b0, 1'b1, 1'b0);
    tbl[6] = mk(16, 15, 1, 1, 18, 1'b0, 1'b0, 1'b1);
    tbl[7] = mk(16, 15, 2, 2,  7, 1'b0, 1'b0, 1'b1);

    bus.i_in_valid  = 1'b0;
    bus.i_in_re     = '0;
    bus.i_in_im     = '0;
    bus.i_in_last   = 1'b0;
    bus.i_core_re   = '0;
    bus.i_core_im   = '0;
    bus.i_core_done = 1'b0;
    bus.i_out_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", W'(bus.o_in_ready), W'(1));
    check("reset_out_valid", W'(bus.o_out_valid), W'(0));
    check("reset_pulses", W'({bus.o_frame_err, bus.o_timeout, bus.o_core_start, bus.o_out_last}), W'(0));
    check("reset_out_idx", W'(bus.o_out_idx), W'(0));
    check("reset_out_re", W'(bus.o_out_re), W'(0));
    check("reset_core_re", bus.o_core_re, W'(0));

    for (int i = 0; i < 8; i++) do_frame(tbl[i], -1);

    // Done asserted during the start cycle is ignored.
    fill_data(1'b0, 2);
    send_frame(16, 15);
    check("early_start", W'(bus.o_core_start), W'(1));
    bus.i_core_done = 1'b1;
    bus.i_core_re   = junk_bus();
    bus.i_core_im   = junk_bus();
    @(negedge clk);
    bus.i_core_done = 1'b0;
    check("early_done_ignored", W'(bus.o_out_valid), W'(0));
    run_core(0);
    drain(2, -1);

    // Core never answers: watchdog fires after TO RUN cycles.
    fill_data(1'b0, 2);
    send_frame(16, 15);
    check("to_start", W'(bus.o_core_start), W'(1));
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.o_out_valid !== 1'b0) check("to_no_out_valid", W'(bus.o_out_valid), W'(0));
      if (bus.o_timeout === 1'b1) begin
        seen = 1'b1;
        bus.i_in_valid = 1'b0;
      end else begin
        bus.i_in_valid = 1'($urandom_range(1));
        bus.i_in_re    = N'($urandom);
      end
    end
    check("timeout_seen", W'(seen), W'(1));
    check("timeout_cycle", W'(cnt), W'(TO));
    check("timeout_in_ready", W'(bus.o_in_ready), W'(1));
    @(negedge clk);
    check("timeout_single", W'(bus.o_timeout), W'(0));

    // Reset while bin 9 is presented, then a clean frame from bin 0.
    rv = mk(16, 15, 0, 2, 3, 1'b0, 1'b0, 1'b1);
    do_frame(rv, 9);
    rv = mk(16, 15, 1, 2, 1, 1'b0, 1'b0, 1'b1);
    do_frame(rv, -1);

    // Value p at position p: natural or bit-reversed sequence per build.
    rv = mk(16, 15, 0, 1, 2, 1'b1, 1'b0, 1'b1);
    do_frame(rv, -1);

    // A few random full frames.
    for (int i = 0; i < 4; i++) begin
      rv = mk(16, 15, 2, 2, int'($urandom_range(6)), 1'b0, 1'b0, 1'b1);
      do_frame(rv, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fft_stream_frame.md
Name: fft_stream_frame

Overview:
- Parametrised stream adapter between a serial complex-sample source and a parallel POINTS-point FFT core (e.g. FFT16_top).
- Collects one frame of samples via a valid/ready handshake and presents it to the core on flat parallel buses with a start pulse.
- Captures the core's parallel result on its done pulse, then streams results out serially with index and last markers.
- Adds framing checks and a core timeout watchdog; the 16-point core has neither.

Parameters:
- N, 16, sample width per real/imag component (two's complement, Q fractional bits; Q is passed through only).
- Q, 8, fractional bits; no arithmetic inside this block.
- POINTS, 16, frame length; power of two, 4..1024.
- TIMEOUT, 256, max cycles in RUN awaiting i_core_done; 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_in_valid  in  1  input sample valid.
- o_in_ready  out  1  high only in FILL.
- i_in_re / i_in_im  in  N  input sample.
- i_in_last  in  1  marks last sample of source frame.
- o_core_re / o_core_im  out  POINTS*N  frame to core; sample k at bits [k*N +: N].
- o_core_start  out  1  one-cycle start pulse.
- i_core_re / i_core_im  in  POINTS*N  core result, same packing.
- i_core_done  in  1  core result valid (sampled only in RUN).
- o_out_valid  out  1  output sample valid.
- i_out_ready  in  1  downstream ready.
- o_out_re / o_out_im  out  N  output sample.
- o_out_idx  out  log2(POINTS)  bin index of current output.
- o_out_last  out  1  high with bin POINTS-1 transfer.
- o_frame_err  out  1  one-cycle pulse on framing error.
- o_timeout  out  1  one-cycle pulse on core timeout.

Behaviour:
- Reset: state=FILL, counters=0, o_core_start=0, o_out_valid=0, o_out_last=0, o_out_idx=0, o_frame_err=0, o_timeout=0.
- Reset: input and output buffers cleared to 0, so o_core_* and o_out_re/im read 0.
- Reset mid-frame discards all data; no pulse is emitted.
- FILL: o_in_ready=1. On each handshake (valid&ready), store the sample at wr_cnt and increment wr_cnt.
- FILL, i_in_last at wr_cnt<POINTS-1: pulse o_frame_err next cycle, wr_cnt<=0, discard frame (sample not stored), stay in FILL.
- FILL, handshake at wr_cnt==POINTS-1: store sample, wr_cnt<=0, go RUN, assert o_core_start in the first RUN cycle only.
- FILL, i_in_last low on that final sample: also pulse o_frame_err, but the frame is still processed.
- o_core_re/im are registered buffers held stable from RUN entry until the next frame overwrites them.
- RUN: o_in_ready=0; timeout counter increments each cycle.
- RUN, i_core_done==1: latch i_core_re/im into the output buffer, go DRAIN. Earliest done is accepted the cycle after start.
- RUN, counter reaches TIMEOUT with no done: pulse o_timeout, go FILL, output buffer unchanged.
- RUN, done and timeout in the same cycle: done wins.
- DRAIN: o_out_valid=1, presenting bin rd_cnt (registered outputs).
- DRAIN, o_out_valid & ~i_out_ready: all outputs hold stable.
- DRAIN, handshake: rd_cnt increments; o_out_last=1 when rd_cnt==POINTS-1.
- DRAIN, last handshake: o_out_valid drops next cycle, rd_cnt<=0, go FILL.
- i_in_valid is ignored outside FILL; i_core_done is ignored outside RUN.
- Zero-bubble throughput is not required.
- Latency: start pulse one cycle after the final input handshake; first o_out_valid one cycle after done is sampled.

Optional Feature:
- FFT_BITREV_EN defined: the core is taken to emit results in bit-reversed order. The result at bit-reversed position rev(k) is emitted as bin k, so the stream is in natural order and o_out_idx=k.
- FFT_BITREV_EN undefined: position k is emitted as bin k, with no reordering.

Decomposition:
- Shared package fft_pkg holds: state encoding (FILL=2'd0, RUN=2'd1, DRAIN=2'd2); default N/Q/POINTS constants; a bit-reverse function parameterised by log2(POINTS).
- One natural sub-module: fft_frame_buf, a POINTS x 2N register array with indexed write, parallel flat read and parallel load. It is instantiated twice, for input and output.

Test Plan:
- Reset, POINTS=16, feed x[k]=k+j0 with i_in_last on k=15 → o_core_start single pulse; o_core_re[k*16+:16]==k; model core done after 5 cycles with i_core_re=x → out bins 0..15 re=0..15, last on 15.
- Backpressure: toggle i_out_ready 1010… → each bin is emitted exactly once and outputs stay stable while stalled.
- i_in_last on sample 7 → o_frame_err pulse and no start; the next full 16-sample frame processes normally.
- Core never asserts done, TIMEOUT=20 → o_timeout on cycle 20 of RUN, o_in_ready=1 next cycle, no o_out_valid.
- i_rst during DRAIN at bin 9 → o_out_valid=0 next cycle; next frame starts at bin 0.
- FFT_BITREV_EN, core returns value p at position p → o_out_re sequence 0,8,4,12,2,10,… with o_out_idx 0..15.
